// File: rtl/rv_reverse_delay_line.sv
// rv_reverse_delay_line: chain of STAGES skid buffers that register the ready path
// and pass data/valid straight through. Optional fill level: RV_REVERSE_DELAY_LINE_LEVEL_EN.
module rv_reverse_delay_line #(
    parameter int DATA_WIDTH = 8,
    parameter int STAGES     = 4
) (
    input  logic                  clock_port,
    input  logic                  reset_port,
    input  logic [DATA_WIDTH-1:0] input_port_data,
    input  logic                  input_port_valid,
    output logic                  input_port_ready,
    output logic [DATA_WIDTH-1:0] output_port_data,
    output logic                  output_port_valid,
    input  logic                  output_port_ready
`ifdef RV_REVERSE_DELAY_LINE_LEVEL_EN
    ,
    output logic [$clog2(STAGES+1)-1:0] fill_level,
    output logic                        full_flag
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    stage_state_e          state_q     [STAGES];
    stage_state_e          state_d     [STAGES];
    logic [DATA_WIDTH-1:0] skid_data_q [STAGES];
    logic [DATA_WIDTH-1:0] skid_data_d [STAGES];

    logic [STAGES-1:0]     skid_v;
    logic [STAGES:0]       vld;
    logic [STAGES:0]       rdy;
    logic [DATA_WIDTH-1:0] dat [STAGES+1];

    // Skid occupancy decoded from each stage's state flop.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            skid_v[k] = (state_q[k] == ST_FULL);
        end
    end

    // Forward valid/data ripple through; each stage's ready is its own flop.
    always_comb begin
        vld[0]      = input_port_valid;
        dat[0]      = input_port_data;
        rdy[STAGES] = output_port_ready;
        for (int k = 0; k < STAGES; k++) begin
            rdy[k]   = ~skid_v[k];
            vld[k+1] = vld[k] | skid_v[k];
            dat[k+1] = skid_v[k] ? skid_data_q[k] : dat[k];
        end
    end

    assign input_port_ready  = rdy[0];
    assign output_port_valid = vld[STAGES];
    assign output_port_data  = dat[STAGES];

    // Per-stage next state: capture when blocked downstream, release when drained.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            state_d[k]     = state_q[k];
            skid_data_d[k] = skid_data_q[k];
            unique case (state_q[k])
                ST_EMPTY: begin
                    if (vld[k] && !rdy[k+1]) begin
                        state_d[k]     = ST_FULL;
                        skid_data_d[k] = dat[k];
                    end
                end
                ST_FULL: begin
                    if (rdy[k+1]) begin
                        state_d[k] = ST_EMPTY;
                    end
                end
                default: state_d[k] = ST_EMPTY;
            endcase
        end
    end

    // Stage state and skid payload registers.
    always_ff @(posedge clock_port or negedge reset_port) begin
        if (!reset_port) begin
            for (int k = 0; k < STAGES; k++) begin
                state_q[k]     <= ST_EMPTY;
                skid_data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                state_q[k]     <= state_d[k];
                skid_data_q[k] <= skid_data_d[k];
            end
        end
    end

`ifdef RV_REVERSE_DELAY_LINE_LEVEL_EN
    localparam int LW = $clog2(STAGES+1);

    logic [STAGES-1:0] cap;
    logic [STAGES-1:0] rel;
    logic [LW-1:0]     level_q;
    logic [LW-1:0]     level_d;
    int                lvl;

    // Per-stage capture and release events feeding the occupancy counter.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            cap[k] = vld[k] & ~skid_v[k] & ~rdy[k+1];
            rel[k] = skid_v[k] & rdy[k+1];
        end
    end

    // Net occupancy change this cycle, clamped to the chain depth.
    always_comb begin
        lvl = int'(level_q);
        for (int k = 0; k < STAGES; k++) begin
            if (cap[k]) lvl = lvl + 1;
            if (rel[k]) lvl = lvl - 1;
        end
        if (lvl > STAGES) lvl = STAGES;
        if (lvl < 0) lvl = 0;
        level_d = LW'(lvl);
    end

    // Occupancy counter register.
    always_ff @(posedge clock_port or negedge reset_port) begin
        if (!reset_port) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign fill_level = level_q;
    assign full_flag  = (level_q == LW'(STAGES));
`endif

endmodule
